// File: rtl/rt_pkg.sv
// Shared types and constants for the reaction-timer controller.
package rt_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARM     = 3'd1,
        GO      = 3'd2,
        DONE    = 3'd3,
        EARLY   = 3'd4,
        TIMEOUT = 3'd5
    } rt_state_e;

    // Right-shifting Fibonacci form: taps 16,14,13,11 land on bits 0,2,3,5.
    localparam logic [15:0] LFSR_TAP_MASK    = 16'h002D;
    localparam int          DEFAULT_TICK_DIV = 50000;

    function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
        return {^(cur & LFSR_TAP_MASK), cur[15:1]};
    endfunction

endpackage

// File: rtl/ms_prescaler.sv
// Millisecond timebase: tick is high in the last cycle of each TICK_DIV-cycle period.
module ms_prescaler
    import rt_pkg::*;
#(
    parameter int TICK_DIV = DEFAULT_TICK_DIV
) (
    input  logic Clock,
    input  logic Clear,
    input  logic restart,
    output logic tick
);

    localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (restart || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge Clock) begin
        if (!Clear) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The counter wraps to 0 on the edge that consumes this pulse.
    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/reaction_timer_ctrl.sv
// Reaction-timer control FSM: button conditioning, random wait, ms enables and clear for the BCD counter.
module reaction_timer_ctrl
    import rt_pkg::*;
#(
    parameter int          TICK_DIV    = DEFAULT_TICK_DIV,
    parameter int          WAIT_MIN_MS = 1000,
    parameter int          WAIT_BITS   = 11,
    parameter int          MAX_MS      = 9999,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic Clock,
    input  logic Clear,
    input  logic Start,
    input  logic React,
    output logic CountEn,
    output logic CountClr_n,
    output logic LED,
    output logic Busy,
    output logic Early,
    output logic Timeout
);

    localparam int WAIT_MAX = WAIT_MIN_MS + (1 << WAIT_BITS) - 1;
    localparam int MS_TOP   = (WAIT_MAX > MAX_MS) ? WAIT_MAX : MAX_MS;
    localparam int MSW      = $clog2(MS_TOP + 1);

    logic [1:0]  btn_raw;
    logic [1:0]  btn_ev;
    logic [1:0]  settle_q, settle_d;
    logic        start_ev, react_ev, tick, restart;
    logic [15:0] lfsr_q, lfsr_d;
    rt_state_e   state_q, state_d;
    logic [MSW-1:0] ms_q, ms_d, wait_q, wait_d;
    logic        early_q, early_d, tmo_q, tmo_d;
    logic        led_q, led_d, busy_q, busy_d, clr_n_q, clr_n_d, cen_q, cen_d;

    assign btn_raw  = {React, Start};
    assign settle_d = {1'b0, settle_q[1]};

    // Edge history is held high until the cleared synchronisers refill, so a
    // button already held through reset never produces an event.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_btn
            logic s1_q, s1_d, s2_q, s2_d, prev_q, prev_d;

            always_comb begin
                s1_d   = btn_raw[gi];
                s2_d   = s1_q;
                prev_d = s2_q | settle_q[0];
            end

            always_ff @(posedge Clock) begin
                if (!Clear) begin
                    s1_q   <= 1'b0;
                    s2_q   <= 1'b0;
                    prev_q <= 1'b1;
                end else begin
                    s1_q   <= s1_d;
                    s2_q   <= s2_d;
                    prev_q <= prev_d;
                end
            end

            assign btn_ev[gi] = s2_q & ~prev_q;
        end
    endgenerate

    assign start_ev = btn_ev[0];
    assign react_ev = btn_ev[1];
    assign lfsr_d   = lfsr_step(lfsr_q);

    ms_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
        .Clock  (Clock),
        .Clear  (Clear),
        .restart(restart),
        .tick   (tick)
    );

    always_comb begin
        state_d = state_q;
        ms_d    = ms_q;
        wait_d  = wait_q;
        early_d = early_q;
        tmo_d   = tmo_q;
        case (state_q)
            IDLE, DONE, EARLY, TIMEOUT: begin
                if (start_ev) begin
                    state_d = ARM;
                    wait_d  = MSW'(WAIT_MIN_MS) + MSW'(lfsr_q[WAIT_BITS-1:0]);
                    early_d = 1'b0;
                    tmo_d   = 1'b0;
                end
            end
            ARM: begin
                // A reaction on the expiring tick still counts as a false start.
                if (react_ev) begin
                    state_d = EARLY;
                    early_d = 1'b1;
                end else if (tick) begin
                    if (ms_q + 1'b1 == wait_q) begin
                        state_d = GO;
                    end else begin
                        ms_d = ms_q + 1'b1;
                    end
                end
            end
            GO: begin
                if (react_ev) begin
                    state_d = DONE;
                end else if (tick) begin
                    if (ms_q + 1'b1 == MSW'(MAX_MS)) begin
                        state_d = TIMEOUT;
                        tmo_d   = 1'b1;
                    end else begin
                        ms_d = ms_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        restart = (state_d != state_q);
        if (restart) begin
            ms_d = '0;
        end

        led_d   = (state_d == GO);
        busy_d  = (state_d == ARM) || (state_d == GO);
        clr_n_d = !((state_d == ARM) && (state_q != ARM));
        // Keyed on the current state so the tick that ends GO is still forwarded.
        cen_d   = tick && (state_q == GO);
    end

    always_ff @(posedge Clock) begin
        if (!Clear) begin
            settle_q <= 2'b11;
            lfsr_q   <= LFSR_SEED;
            state_q  <= IDLE;
            ms_q     <= '0;
            wait_q   <= '0;
            early_q  <= 1'b0;
            tmo_q    <= 1'b0;
            led_q    <= 1'b0;
            busy_q   <= 1'b0;
            clr_n_q  <= 1'b0;
            cen_q    <= 1'b0;
        end else begin
            settle_q <= settle_d;
            lfsr_q   <= lfsr_d;
            state_q  <= state_d;
            ms_q     <= ms_d;
            wait_q   <= wait_d;
            early_q  <= early_d;
            tmo_q    <= tmo_d;
            led_q    <= led_d;
            busy_q   <= busy_d;
            clr_n_q  <= clr_n_d;
            cen_q    <= cen_d;
        end
    end

    assign CountEn    = cen_q;
    assign CountClr_n = clr_n_q;
    assign LED        = led_q;
    assign Busy       = busy_q;
    assign Early      = early_q;
    assign Timeout    = tmo_q;

endmodule

// File: tb/tb_reaction_timer_ctrl.sv
// Scoreboard bench for reaction_timer_ctrl: each round's outcome is predicted from timing rules and checked by a monitor.
module tb_reaction_timer_ctrl;

    localparam int          TD    = 4;
    localparam int          WMIN  = 2;
    localparam int          WB    = 2;
    localparam int          MAXMS = 20;
    localparam logic [15:0] SEED  = 16'hACE1;

    localparam int K_DONE = 0, K_EARLY = 1, K_TMO = 2, K_COLL = 3;

    logic Clock = 1'b0;
    logic Clear = 1'b0;
    logic Start = 1'b0;
    logic React = 1'b0;
    logic CountEn, CountClr_n, LED, Busy, Early, Timeout;

    reaction_timer_ctrl #(
        .TICK_DIV   (TD),
        .WAIT_MIN_MS(WMIN),
        .WAIT_BITS  (WB),
        .MAX_MS     (MAXMS),
        .LFSR_SEED  (SEED)
    ) dut (
        .Clock     (Clock),
        .Clear     (Clear),
        .Start     (Start),
        .React     (React),
        .CountEn   (CountEn),
        .CountClr_n(CountClr_n),
        .LED       (LED),
        .Busy      (Busy),
        .Early     (Early),
        .Timeout   (Timeout)
    );

    always #5 Clock = ~Clock;

    // cyc = index of the most recent rising edge; last_rst = last edge sampled with Clear low.
    int cyc = 0;
    int last_rst = 0;
    always @(posedge Clock) begin
        cyc <= cyc + 1;
        if (!Clear) last_rst <= cyc + 1;
    end

    typedef struct {
        int kind;
        int led_t;
        int cnt;
    } rnd_t;

    rnd_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   round_no = 0;

    task automatic chk(input string name, input int got, input int expv);
        tests++;
        if (got != expv) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, expv, cyc);
        end
    endtask

    // Reference LFSR: seed stepped n times with feedback bit0^bit2^bit3^bit5 into bit 15.
    function automatic logic [15:0] lfsr_after(input int n);
        logic [15:0] v;
        v = SEED;
        for (int i = 0; i < n; i++) v = {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
        return v;
    endfunction

    // Monitor: a round opens at the ARM-entry clear pulse and closes when Busy falls.
    logic in_round = 1'b0;
    logic prev_busy = 1'b0;
    int   t0, led_t, cnt;
    always @(negedge Clock) begin
        rnd_t e;
        if (last_rst == cyc) begin
            in_round = 1'b0;
        end else begin
            if (CountClr_n === 1'b0 && Busy === 1'b1) begin
                in_round = 1'b1;
                t0 = cyc;
                led_t = -1;
                cnt = 0;
                chk("arm_entry_cen_early_tmo", int'({CountEn, Early, Timeout}), 0);
            end
            if (in_round) begin
                if (LED && led_t < 0) led_t = cyc - t0;
                if (CountEn) cnt++;
                if (prev_busy && !Busy) begin
                    in_round = 1'b0;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_round_end", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        $display("[TB] round %0d: kind=%0d led_delay=%0d/%0d countEn=%0d/%0d early=%0b timeout=%0b",
                                 round_no, e.kind, led_t, e.led_t, cnt, e.cnt, Early, Timeout);
                        chk("round_early", int'(Early), (e.kind == K_EARLY) ? 1 : 0);
                        chk("round_timeout", int'(Timeout), (e.kind == K_TMO) ? 1 : 0);
                        chk("round_led_delay", led_t, e.led_t);
                        chk("round_counten_pulses", cnt, e.cnt);
                        chk("round_led_off", int'(LED), 0);
                    end
                end
            end
        end
        prev_busy = Busy;
    end

    task automatic wait_idle();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 1000) begin
            @(negedge Clock);
            guard++;
        end
        if (exp_q.size() != 0) begin
            chk("round_completion_bound", exp_q.size(), 0);
            exp_q.delete();
        end
        repeat ($urandom_range(3, 8)) @(negedge Clock);
    endtask

    // One round: Start rises at negedge n, so the FSM enters ARM on edge n+3 and GO on edge n+3+4*wait.
    task automatic run_round(input int kind, input int k);
        int n, E, G, w, R, ns, r_on, r_off, last;
        int st_on[3], st_off[3];
        logic [15:0] lv;
        rnd_t e;
        @(negedge Clock);
        n  = cyc;
        lv = lfsr_after(n + 2 - last_rst);
        w  = WMIN + int'(lv[WB-1:0]);
        E  = n + 3;
        G  = E + TD * w;
        ns = 1;
        st_on[0] = n;
        st_off[0] = n + 2;
        R = -1;
        case (kind)
            K_DONE: begin
                R = G + TD * k + $urandom_range(0, TD - 1);
                ns = 3;
                st_on[1] = E + 1; st_off[1] = E + 3;
                st_on[2] = G + 1; st_off[2] = G + 3;
                e = '{K_DONE, TD * w, k};
            end
            K_EARLY: begin
                R = E + 1 + $urandom_range(0, TD * w - 2);
                e = '{K_EARLY, -1, 0};
            end
            K_COLL: begin
                R = G;
                e = '{K_EARLY, -1, 0};
            end
            default: e = '{K_TMO, TD * w, MAXMS};
        endcase
        r_on  = (R > 0) ? R - 3 : 0;
        r_off = (R > 0) ? r_on + $urandom_range(1, 6) : 0;
        last  = r_off;
        for (int i = 0; i < ns; i++) if (st_off[i] > last) last = st_off[i];
        round_no++;
        exp_q.push_back(e);
        for (int c = 0; c < 400; c++) begin
            Start = 1'b0;
            for (int i = 0; i < ns; i++) if (cyc >= st_on[i] && cyc < st_off[i]) Start = 1'b1;
            React = (R > 0) && (cyc >= r_on) && (cyc < r_off);
            if (cyc >= last) break;
            @(negedge Clock);
        end
        Start = 1'b0;
        React = 1'b0;
        wait_idle();
    endtask

    // Reset pulse in GO with Start held high across it.
    task automatic mid_go_reset();
        int n, E, G, w;
        logic [15:0] lv;
        @(negedge Clock);
        n  = cyc;
        lv = lfsr_after(n + 2 - last_rst);
        w  = WMIN + int'(lv[WB-1:0]);
        E  = n + 3;
        G  = E + TD * w;
        round_no++;
        for (int c = 0; c < 200; c++) begin
            Start = (cyc < n + 2);
            if (cyc >= G + 2) break;
            @(negedge Clock);
        end
        chk("midgo_led_before_reset", int'(LED), 1);
        Start = 1'b1;
        Clear = 1'b0;
        @(negedge Clock);
        Clear = 1'b1;
        chk("midgo_led_after_reset", int'(LED), 0);
        chk("midgo_clr_n_after_reset", int'(CountClr_n), 0);
        chk("midgo_busy_after_reset", int'(Busy), 0);
        chk("midgo_counten_after_reset", int'(CountEn), 0);
        $display("[TB] round %0d: mid-GO reset, LED=%0b CountClr_n=%0b Busy=%0b", round_no, LED, CountClr_n, Busy);
        for (int i = 0; i < 8; i++) begin
            @(negedge Clock);
            chk("held_start_no_event_busy", int'(Busy), 0);
        end
        chk("held_start_clr_n_idle", int'(CountClr_n), 1);
        Start = 1'b0;
        repeat (5) @(negedge Clock);
    endtask

    initial begin
        @(negedge Clock);
        chk("reset_outputs_c1", int'({CountEn, CountClr_n, LED, Busy, Early, Timeout}), 0);
        @(negedge Clock);
        chk("reset_outputs_c2", int'({CountEn, CountClr_n, LED, Busy, Early, Timeout}), 0);
        Clear = 1'b1;
        @(negedge Clock);
        chk("post_reset_clr_n", int'(CountClr_n), 1);
        chk("post_reset_others", int'({CountEn, LED, Busy, Early, Timeout}), 0);
        $display("[TB] reset released: CountClr_n=%0b Busy=%0b", CountClr_n, Busy);
        repeat (4) @(negedge Clock);

        run_round(K_DONE, 3);
        run_round(K_EARLY, 0);
        run_round(K_DONE, 2);
        run_round(K_COLL, 0);
        run_round(K_TMO, 0);
        for (int i = 0; i < 12; i++) begin
            int sel;
            sel = $urandom_range(0, 2);
            if (sel == 0)      run_round(K_DONE, $urandom_range(1, 6));
            else if (sel == 1) run_round(K_EARLY, 0);
            else               run_round(K_COLL, 0);
        end
        mid_go_reset();
        run_round(K_DONE, 4);
        run_round(K_TMO, 0);
        run_round(K_EARLY, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
